// File: rtl/ufifo_arb_pkg.sv
// Shared types, widths and helpers for the ufifo write-port arbiter.
package ufifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  localparam int unsigned ARB_CNTW   = 4;
  localparam int unsigned ARB_MAXREQ = 8;
  localparam int unsigned ARB_IDXW   = 3;

  // One-hot decode at the widest supported requester count; callers truncate.
  function automatic logic [ARB_MAXREQ-1:0] onehot(input logic [ARB_IDXW-1:0] idx);
    logic [ARB_MAXREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/ufifo_wr_arb_rr_pick.sv
// Round-robin pick: first set request searching upward from ptr+1 (mod NREQ).
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   pick,
  output logic            any
);

  logic [PW-1:0] cand;

  // Walk from farthest to nearest so the nearest requester wins.
  always_comb begin
    pick = ptr;
    cand = '0;
    any  = |req;
    for (int i = int'(NREQ); i >= 1; i--) begin
      cand = PW'((int'(ptr) + i) % int'(NREQ));
      if (req[cand]) begin
        pick = cand;
      end
    end
  end

endmodule

// File: rtl/ufifo_wr_arb.sv
// Round-robin burst arbiter for the single write port of a TX-mode ufifo.
// Define UFIFO_ARB_STATS_EN to add the o_stalls / o_words statistics ports.
module ufifo_wr_arb
  import ufifo_arb_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned BW       = 8,
  parameter int unsigned LGFLEN   = 4,
  parameter int unsigned MAXBURST = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ*BW-1:0] i_data,
  input  logic [NREQ-1:0]    i_last,
  output logic [NREQ-1:0]    o_ack,
  output logic [NREQ-1:0]    o_grant,
  output logic               o_wr,
  output logic [BW-1:0]      o_data,
  input  logic [LGFLEN-1:0]  i_space,
`ifdef UFIFO_ARB_STATS_EN
  output logic [15:0]        o_stalls,
  output logic [15:0]        o_words,
`endif
  output logic               o_busy
);

  localparam int unsigned PW = $clog2(NREQ);

  arb_state_e          state, state_d;
  logic [PW-1:0]       ptr, ptr_d;
  logic [PW-1:0]       owner, owner_d;
  logic [PW-1:0]       pick;
  logic                any;
  logic [ARB_CNTW-1:0] cnt, cnt_d;
  logic [NREQ-1:0]     grant_d;
  logic                wr_d;
  logic [BW-1:0]       data_d;
  logic                owner_req;
  logic                owner_last;
  logic [BW-1:0]       owner_data;
  logic                accept;
  logic                burst_end;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req  (i_req),
    .ptr  (ptr),
    .pick (pick),
    .any  (any)
  );

  assign owner_req  = i_req[owner];
  assign owner_last = i_last[owner];
  assign owner_data = i_data[32'(owner) * BW +: BW];

  // A write still in flight has not yet been subtracted from i_space.
  assign accept    = (state == ARB_BURST) && owner_req && !i_rst &&
                     (i_space > LGFLEN'(o_wr));
  assign burst_end = owner_last || (cnt == ARB_CNTW'(MAXBURST - 1));
  assign o_busy    = (state == ARB_BURST);

  // Next-state, ack and output-register decode.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    owner_d = owner;
    cnt_d   = cnt;
    wr_d    = 1'b0;
    data_d  = o_data;
    o_ack   = '0;
    case (state)
      ARB_IDLE: begin
        if (any) begin
          owner_d = pick;
          ptr_d   = pick;
          cnt_d   = '0;
          state_d = ARB_BURST;
        end
      end
      ARB_BURST: begin
        if (accept) begin
          o_ack  = NREQ'(onehot(ARB_IDXW'(owner)));
          wr_d   = 1'b1;
          data_d = owner_data;
          cnt_d  = cnt + ARB_CNTW'(1);
          if (burst_end) begin
            state_d = ARB_IDLE;
          end
        end else if (!owner_req) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
    grant_d = (state_d == ARB_BURST) ? NREQ'(onehot(ARB_IDXW'(owner_d))) : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ARB_IDLE;
      ptr     <= PW'(NREQ - 1);
      owner   <= '0;
      cnt     <= '0;
      o_grant <= '0;
      o_wr    <= 1'b0;
      o_data  <= '0;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      owner   <= owner_d;
      cnt     <= cnt_d;
      o_grant <= grant_d;
      o_wr    <= wr_d;
      o_data  <= data_d;
    end
  end

`ifdef UFIFO_ARB_STATS_EN
  // Stalls saturate so a long back-pressure episode never reads as a small count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stalls <= '0;
      o_words  <= '0;
    end else begin
      if ((state == ARB_BURST) && owner_req && !accept && (o_stalls != 16'hFFFF)) begin
        o_stalls <= o_stalls + 16'd1;
      end
      if (accept) begin
        o_words <= o_words + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ufifo_wr_arb.sv
// Self-checking bench for ufifo_wr_arb: directed tables, corner sequences and
// randomized traffic against a word/burst-level reference model.
module tb_ufifo_wr_arb;

  localparam int NREQ     = 4;
  localparam int BW       = 8;
  localparam int LGFLEN   = 4;
  localparam int MAXBURST = 4;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*BW-1:0] data_in;
  logic [NREQ-1:0]    last;
  logic [NREQ-1:0]    o_ack;
  logic [NREQ-1:0]    o_grant;
  logic               o_wr;
  logic [BW-1:0]      o_data;
  logic [LGFLEN-1:0]  space_in;
  logic               o_busy;
`ifdef UFIFO_ARB_STATS_EN
  logic [15:0]        o_stalls;
  logic [15:0]        o_words;
`endif

  ufifo_wr_arb #(
    .NREQ(NREQ), .BW(BW), .LGFLEN(LGFLEN), .MAXBURST(MAXBURST)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_req   (req),
    .i_data  (data_in),
    .i_last  (last),
    .o_ack   (o_ack),
    .o_grant (o_grant),
    .o_wr    (o_wr),
    .o_data  (o_data),
    .i_space (space_in),
`ifdef UFIFO_ARB_STATS_EN
    .o_stalls(o_stalls),
    .o_words (o_words),
`endif
    .o_busy  (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the port, how many words it has sent, what was written.
  bit        m_busy   = 0;
  int        m_owner  = 0;
  int        m_ptr    = NREQ - 1;
  int        m_cnt    = 0;
  bit        m_wr     = 0;
  logic [7:0] m_data  = '0;
  int        m_stalls = 0;
  int        m_words  = 0;

  // FIFO free-slot model used by the randomized phase.
  bit fifo_on   = 0;
  int space     = 15;
  int drain_div = 2;

  typedef struct {
    logic [3:0] req;
    logic [3:0] last;
    logic [3:0] space;
    logic [7:0] d;
    logic [3:0] ack;
    logic [3:0] grant;
    logic       wr;
    logic [7:0] data;
    logic       busy;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare against the model, clock the DUT, advance the model.
  task automatic tick(output logic [NREQ-1:0] eack);
    bit acc;
    #1;
    acc  = !rst && m_busy && req[m_owner] && (int'(space_in) > (m_wr ? 1 : 0));
    eack = acc ? NREQ'(1 << m_owner) : '0;
    if (!rst) chk("ack", 32'(o_ack), 32'(eack));
    chk("grant", 32'(o_grant), m_busy ? 32'(1 << m_owner) : 32'd0);
    chk("wr", 32'(o_wr), 32'(m_wr));
    chk("data", 32'(o_data), 32'(m_data));
    chk("busy", 32'(o_busy), 32'(m_busy));
`ifdef UFIFO_ARB_STATS_EN
    chk("stalls", 32'(o_stalls), 32'(m_stalls));
    chk("words", 32'(o_words), 32'(m_words));
`endif
    @(posedge clk);
    if (fifo_on) begin
      space = space - (m_wr ? 1 : 0);
      chk("no_overflow", 32'(space < 0), 32'd0);
      if (space < 15 && $urandom_range(0, drain_div - 1) == 0) space++;
    end
    if (rst) begin
      m_busy = 0; m_owner = 0; m_ptr = NREQ - 1; m_cnt = 0;
      m_wr = 0; m_data = '0; m_stalls = 0; m_words = 0;
    end else if (m_busy) begin
      if (acc) begin
        m_wr    = 1;
        m_data  = data_in[m_owner*BW +: BW];
        m_cnt++;
        m_words = (m_words + 1) % 65536;
        if (last[m_owner] || m_cnt == MAXBURST) m_busy = 0;
      end else begin
        m_wr = 0;
        if (req[m_owner]) begin
          if (m_stalls < 65535) m_stalls++;
        end else begin
          m_busy = 0;
        end
      end
    end else begin
      m_wr = 0;
      for (int k = 1; k <= NREQ; k++) begin
        if (!m_busy && req[(m_ptr + k) % NREQ]) begin
          m_busy  = 1;
          m_owner = (m_ptr + k) % NREQ;
          m_ptr   = m_owner;
          m_cnt   = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NREQ-1:0] eack;
    logic [NREQ-1:0] pend;
    logic [3:0]      eg;

    rst = 1'b1; req = '0; last = '0; data_in = '0; space_in = 4'd15; pend = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_grant", 32'(o_grant), 32'd0);
    chk("reset_wr", 32'(o_wr), 32'd0);
    chk("reset_data", 32'(o_data), 32'd0);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_ack", 32'(o_ack), 32'd0);

    // Three-word burst from requester 0, then a space-limited burst from requester 1.
    tbl[0]  = '{4'h1, 4'h0, 4'd15, 8'hA1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{4'h1, 4'h0, 4'd15, 8'hA1, 4'h1, 4'h1, 1'b0, 8'h00, 1'b1};
    tbl[2]  = '{4'h1, 4'h0, 4'd15, 8'hA2, 4'h1, 4'h1, 1'b1, 8'hA1, 1'b1};
    tbl[3]  = '{4'h1, 4'h1, 4'd15, 8'hA3, 4'h1, 4'h1, 1'b1, 8'hA2, 1'b1};
    tbl[4]  = '{4'h0, 4'h0, 4'd15, 8'h00, 4'h0, 4'h0, 1'b1, 8'hA3, 1'b0};
    tbl[5]  = '{4'h0, 4'h0, 4'd15, 8'h00, 4'h0, 4'h0, 1'b0, 8'hA3, 1'b0};
    tbl[6]  = '{4'h2, 4'h0, 4'd1,  8'hB1, 4'h0, 4'h0, 1'b0, 8'hA3, 1'b0};
    tbl[7]  = '{4'h2, 4'h0, 4'd1,  8'hB1, 4'h2, 4'h2, 1'b0, 8'hA3, 1'b1};
    tbl[8]  = '{4'h2, 4'h0, 4'd1,  8'hB2, 4'h0, 4'h2, 1'b1, 8'hB1, 1'b1};
    tbl[9]  = '{4'h2, 4'h0, 4'd0,  8'hB2, 4'h0, 4'h2, 1'b0, 8'hB1, 1'b1};
    tbl[10] = '{4'h2, 4'h0, 4'd0,  8'hB2, 4'h0, 4'h2, 1'b0, 8'hB1, 1'b1};
    tbl[11] = '{4'h2, 4'h0, 4'd3,  8'hB2, 4'h2, 4'h2, 1'b0, 8'hB1, 1'b1};
    tbl[12] = '{4'h2, 4'h2, 4'd3,  8'hB3, 4'h2, 4'h2, 1'b1, 8'hB2, 1'b1};
    tbl[13] = '{4'h0, 4'h0, 4'd3,  8'h00, 4'h0, 4'h0, 1'b1, 8'hB3, 1'b0};
    tbl[14] = '{4'h0, 4'h0, 4'd3,  8'h00, 4'h0, 4'h0, 1'b0, 8'hB3, 1'b0};

    for (int i = 0; i < 15; i++) begin
      req = tbl[i].req; last = tbl[i].last; space_in = tbl[i].space;
      data_in = {NREQ{tbl[i].d}};
      #1;
      chk($sformatf("tbl%0d_ack", i), 32'(o_ack), 32'(tbl[i].ack));
      chk($sformatf("tbl%0d_grant", i), 32'(o_grant), 32'(tbl[i].grant));
      chk($sformatf("tbl%0d_wr", i), 32'(o_wr), 32'(tbl[i].wr));
      chk($sformatf("tbl%0d_data", i), 32'(o_data), 32'(tbl[i].data));
      chk($sformatf("tbl%0d_busy", i), 32'(o_busy), 32'(tbl[i].busy));
      tick(eack);
    end

    // All requesters busy: owners 0,1,2,3,0, four words each, one idle cycle between.
    rst = 1'b1; req = '0; last = '0; space_in = 4'd15;
    tick(eack);
    rst = 1'b0; req = 4'hF; data_in = 32'h44332211;
    for (int c = 0; c < 26; c++) begin
      #1;
      eg = (c % 5 == 0) ? 4'h0 : 4'(1 << (((c - 1) / 5) % 4));
      chk($sformatf("rot%0d_grant", c), 32'(o_grant), 32'(eg));
      chk($sformatf("rot%0d_ack", c), 32'(o_ack), 32'(eg));
      tick(eack);
    end

    // Reset two words into a burst drops the pending word; requester 0 wins afterwards.
    req = '0; rst = 1'b1;
    tick(eack);
    rst = 1'b0; req = 4'h1; data_in = 32'h5D5C5B5A;
    repeat (3) tick(eack);
    rst = 1'b1;
    tick(eack);
    rst = 1'b0; req = 4'h3;
    #1;
    chk("rstmid_wr", 32'(o_wr), 32'd0);
    chk("rstmid_busy", 32'(o_busy), 32'd0);
    chk("rstmid_grant", 32'(o_grant), 32'd0);
    tick(eack);
    #1;
    chk("rstmid_regrant", 32'(o_grant), 32'h1);
    last = 4'h1;
    tick(eack);

    // Owner 1 drops its request after one word; rotation continues from 1.
    last = '0; req = 4'h2;
    tick(eack);
    tick(eack);
    req = 4'hD;
    #1;
    chk("drop_ack", 32'(o_ack), 32'd0);
    tick(eack);
    #1;
    chk("drop_idle", 32'(o_busy), 32'd0);
    chk("drop_grant0", 32'(o_grant), 32'd0);
    tick(eack);
    #1;
    chk("drop_regrant", 32'(o_grant), 32'h4);
    req = '0;
    repeat (2) tick(eack);

`ifdef UFIFO_ARB_STATS_EN
    // Five blocked cycles count as stalls and take no words.
    rst = 1'b1;
    tick(eack);
    rst = 1'b0; req = 4'h1; space_in = 4'd0;
    repeat (6) tick(eack);
    #1;
    chk("stats_stalls", 32'(o_stalls), 32'd5);
    chk("stats_words", 32'(o_words), 32'd0);
    space_in = 4'd15;
    repeat (3) tick(eack);
    req = '0;
    repeat (2) tick(eack);
`endif

    // Randomized traffic against the model, with a modelled FIFO supplying i_space.
    rst = 1'b1;
    tick(eack);
    rst = 1'b0; fifo_on = 1; space = 15; pend = '0; req = '0; last = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      drain_div = (cyc < 1500) ? 2 : 6;
      for (int k = 0; k < NREQ; k++) begin
        if (!pend[k]) begin
          if ($urandom_range(0, 1) == 1) begin
            pend[k] = 1'b1;
            data_in[k*BW +: BW] = 8'($urandom);
            last[k] = ($urandom_range(0, 3) == 0);
          end
        end else if ($urandom_range(0, 39) == 0) begin
          pend[k] = 1'b0;
        end
      end
      req      = pend;
      rst      = ($urandom_range(0, 399) == 0);
      space_in = 4'(space);
      tick(eack);
      pend = pend & ~eack;
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
